// File: rtl/s2p.sv
// rtl/s2p.sv - serial-to-parallel deserializer with one-word holding register
module s2p #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_val,
  output logic         ser_ready,
  input  logic         ser_data,
  output logic         par_valid,
  input  logic         par_ready,
  output logic [N-1:0] par_data,
  input  logic         clr,
  output logic         busy
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-2:0]  shift_q, shift_d;
  logic [N-1:0]  pdata_q, pdata_d;
  logic          pvalid_q, pvalid_d;

  logic          last_bit;
  logic          accept;
  logic          complete;
  logic [N-1:0]  word;

  // The completing bit is the only one that must wait for a free holding register;
  // earlier bits of the next word go into the shift register regardless.
  assign last_bit  = (cnt_q == LAST);
  assign ser_ready = !clr && !(last_bit && pvalid_q && !par_ready);
  assign accept    = ser_val && ser_ready;
  assign complete  = accept && last_bit;
  assign word      = {shift_q, ser_data};

  assign par_valid = pvalid_q;
  assign par_data  = pdata_q;
  assign busy      = (cnt_q != '0);

  // Next-state: shift/count on accepted bits, hand off to the holding register on the N-th
  always_comb begin
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;

    if (clr) begin
      cnt_d = '0;
    end else if (accept) begin
      if (last_bit) begin
        pdata_d = word;
        cnt_d   = '0;
      end else begin
        shift_d = word[N-2:0];
        cnt_d   = cnt_q + CW'(1);
      end
    end

    // A completion in the same cycle as a consume keeps par_valid high (no bubble)
    if (complete) begin
      pvalid_d = 1'b1;
    end else if (par_ready) begin
      pvalid_d = 1'b0;
    end
  end

  // State registers; reset discards both the partial and the pending word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

endmodule

// File: tb/tb_s2p.sv
// tb/tb_s2p.sv - directed table-driven bench for s2p
module tb_s2p;

  logic       clk;
  logic       rstn;
  logic       ser_val;
  logic       ser_ready;
  logic       ser_data;
  logic       par_valid;
  logic       par_ready;
  logic [3:0] par_data;
  logic       clr;
  logic       busy;

  int tests;
  int failed;

  typedef struct {
    logic       val;
    logic       d;
    logic       pr;
    logic       clr;
    logic       sr;
    logic       pv;
    logic [3:0] pd;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  s2p #(.N(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_val   (ser_val),
    .ser_ready (ser_ready),
    .ser_data  (ser_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .par_data  (par_data),
    .clr       (clr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic val, input logic d, input logic pr, input logic c,
                     input logic sr, input logic pv, input logic [3:0] pd, input logic b);
    vec_t v;
    v.val = val; v.d = d; v.pr = pr; v.clr = c;
    v.sr = sr; v.pv = pv; v.pd = pd; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic val, input logic d, input logic pr, input logic c);
    @(negedge clk);
    ser_val = val; ser_data = d; par_ready = pr; clr = c;
  endtask

  int pulses;
  logic [3:0] seen;

  initial begin
    tests = 0; failed = 0;
    rstn = 1'b0; ser_val = 1'b0; ser_data = 1'b0; par_ready = 1'b1; clr = 1'b0;

    // val d pr clr | ser_ready (before edge) | par_valid par_data busy (after edge)
    // Basic word 1011
    add(1,1,1,0, 1, 0,4'h0,1);
    add(1,0,1,0, 1, 0,4'h0,1);
    add(1,1,1,0, 1, 0,4'h0,1);
    add(1,1,1,0, 1, 1,4'hB,0);
    // Back-to-back 0xA then 0x5
    add(1,1,1,0, 1, 0,4'hB,1);
    add(1,0,1,0, 1, 0,4'hB,1);
    add(1,1,1,0, 1, 0,4'hB,1);
    add(1,0,1,0, 1, 1,4'hA,0);
    add(1,0,1,0, 1, 0,4'hA,1);
    add(1,1,1,0, 1, 0,4'hA,1);
    add(1,0,1,0, 1, 0,4'hA,1);
    add(1,1,1,0, 1, 1,4'h5,0);
    add(0,0,1,0, 1, 0,4'h5,0);
    // Backpressure: 0xC held, 3 bits of 0x3 accepted, completing bit stalls
    add(1,1,0,0, 1, 0,4'h5,1);
    add(1,1,0,0, 1, 0,4'h5,1);
    add(1,0,0,0, 1, 0,4'h5,1);
    add(1,0,0,0, 1, 1,4'hC,0);
    add(1,0,0,0, 1, 1,4'hC,1);
    add(1,0,0,0, 1, 1,4'hC,1);
    add(1,1,0,0, 1, 1,4'hC,1);
    add(1,1,0,0, 0, 1,4'hC,1);
    add(1,1,0,0, 0, 1,4'hC,1);
    add(1,1,1,0, 1, 1,4'h3,0);
    add(0,0,1,0, 1, 0,4'h3,0);
    // ser_val gaps (idle data = 1 must be ignored): 0x9
    add(1,1,1,0, 1, 0,4'h3,1);
    add(0,1,1,0, 1, 0,4'h3,1);
    add(1,0,1,0, 1, 0,4'h3,1);
    add(0,1,1,0, 1, 0,4'h3,1);
    add(1,0,1,0, 1, 0,4'h3,1);
    add(0,1,1,0, 1, 0,4'h3,1);
    add(1,1,1,0, 1, 1,4'h9,0);
    add(0,0,1,0, 1, 0,4'h9,0);
    // clr after bits 1,1 then 0x6
    add(1,1,1,0, 1, 0,4'h9,1);
    add(1,1,1,0, 1, 0,4'h9,1);
    add(1,1,1,1, 0, 0,4'h9,0);
    add(1,0,1,0, 1, 0,4'h9,1);
    add(1,1,1,0, 1, 0,4'h9,1);
    add(1,1,1,0, 1, 0,4'h9,1);
    add(1,0,1,0, 1, 1,4'h6,0);
    add(0,0,1,0, 1, 0,4'h6,0);

    // Reset state
    #12;
    check("reset_par_valid", {31'd0, par_valid}, 32'd0);
    check("reset_par_data", {28'd0, par_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("reset_ser_ready", {31'd0, ser_ready}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].val, vecs[i].d, vecs[i].pr, vecs[i].clr);
      #1;
      check($sformatf("v%0d_ser_ready", i), {31'd0, ser_ready}, {31'd0, vecs[i].sr});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_par_valid", i), {31'd0, par_valid}, {31'd0, vecs[i].pv});
      check($sformatf("v%0d_par_data", i), {28'd0, par_data}, {28'd0, vecs[i].pd});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
    end

    // Async reset mid-word after 3 bits
    drive(1,1,1,0); drive(1,1,1,0); drive(1,1,1,0);
    @(posedge clk); #2;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_par_valid", {31'd0, par_valid}, 32'd0);
    check("mid_rst_par_data", {28'd0, par_data}, 32'd0);
    drive(0,0,1,0);
    rstn = 1'b1;

    // Async reset with a pending word
    drive(1,1,0,0); drive(1,0,0,0); drive(1,1,0,0); drive(1,0,0,0);
    @(posedge clk); #2;
    check("pend_pre_par_valid", {31'd0, par_valid}, 32'd1);
    check("pend_pre_par_data", {28'd0, par_data}, 32'hA);
    rstn = 1'b0;
    #1;
    check("pend_rst_par_valid", {31'd0, par_valid}, 32'd0);
    check("pend_rst_par_data", {28'd0, par_data}, 32'd0);
    drive(0,0,1,0);
    rstn = 1'b1;

    // Exactly one clean word after reset
    pulses = 0; seen = 4'h0;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: drive(1,0,1,0);
        1: drive(1,1,1,0);
        2: drive(1,0,1,0);
        3: drive(1,1,1,0);
        default: drive(0,0,1,0);
      endcase
      @(posedge clk); #1;
      if (par_valid) begin
        pulses++;
        seen = par_data;
      end
    end
    check("post_rst_pulses", pulses, 32'd1);
    check("post_rst_word", {28'd0, seen}, 32'h5);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/s2p.md
Name: s2p

Overview:
Serial-to-parallel deserializer; the receive-side counterpart of the team's p2s serializer. It collects N serial bits over a valid/ready serial handshake and presents each completed word on a valid/ready parallel handshake. It sits where a serial code stream must be turned back into a parallel code word, e.g. a loopback or a remote keypad link into the safe-lock datapath. A one-word holding register plus the shift register give full streaming throughput with correct backpressure.

Parameters:
N, 4, word width in bits (legal range N >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
ser_val  input  1  serial bit valid from upstream
ser_ready  output  1  s2p can accept a serial bit this cycle
ser_data  input  1  serial data bit, MSB of word first
par_valid  output  1  par_data holds a complete word
par_ready  input  1  downstream accepts the word this cycle
par_data  output  N  deserialized word
clr  input  1  synchronous abort; discards the partially assembled word
busy  output  1  a partial word (1..N-1 bits) is held in the shift register

Behaviour:
- Reset (rstn=0, async): par_valid=0, par_data=0, busy=0, bit counter=0, shift register=0. ser_ready=1 once rstn=1 and clr=0.
- Serial accept: a bit is accepted when ser_val && ser_ready at the rising edge. Otherwise nothing changes on the serial side.
- Bit order is MSB first, matching p2s: the first accepted bit lands in par_data[N-1] and the N-th lands in par_data[0].
- Bit counter cnt ranges 0..N-1, width $clog2(N).
- Accepting a bit with cnt<N-1: shift_reg <= {shift_reg[N-2:0], ser_data}; cnt <= cnt+1.
- Accepting a bit with cnt==N-1: par_data <= {shift_reg[N-2:0], ser_data}; par_valid <= 1; cnt <= 0.
- Latency: par_valid rises on the clock edge that accepts the N-th bit, i.e. visible in the following cycle.
- ser_ready = !clr && !(cnt==N-1 && par_valid && !par_ready). This is combinational on par_ready and clr.
- Bits 1..N-1 of the next word are always accepted while a word is waiting. Only the completing bit stalls.
- Parallel side, par_valid && par_ready with no word completing in the same cycle: par_valid <= 0. par_data keeps its last value.
- Parallel side, par_valid && par_ready with a word completing in the same cycle: par_valid stays 1 and par_data takes the new word. No bubble.
- While par_valid && !par_ready, par_data and par_valid are held stable.
- clr=1: cnt <= 0 and no serial bit is accepted (ser_ready=0). The holding register and par_valid are unaffected, and the parallel handshake proceeds normally.
- busy = (cnt != 0), registered state.
- Reset mid-word or with a pending word: everything is discarded immediately. No partial word is ever output.
- ser_data is ignored when ser_val=0.
- Sustained throughput is 1 bit/clk and 1 word every N clk when par_ready is held at 1.

Test Plan:
1. N=4, reset, par_ready=1, stream bits 1,0,1,1 with ser_val=1 on four consecutive cycles -> par_valid=1 for one cycle with par_data=4'b1011; busy is 1 after the first bit and returns to 0 after the fourth; ser_ready stays 1.
2. Back-to-back streaming of 0xA then 0x5 (8 consecutive bits), par_ready=1 -> par_valid pulses on cycle 4 with 0xA and on cycle 8 with 0x5; ser_ready never drops.
3. Backpressure: par_ready=0, send 0xC then 3 bits of 0x3 -> all 3 bits accepted and par_data=0xC held. The 4th bit sees ser_ready=0 and is held by upstream. Raise par_ready -> 0xC consumed and 0x3 loaded the same cycle; par_valid stays 1.
4. ser_val gaps: send 0x9 with ser_val low on alternate cycles -> par_data=0x9; the idle cycles do not advance cnt.
5. clr after 2 bits (1,1), then send 0x6 -> no output for the aborted bits; par_data=0x6. ser_ready=0 in the clr cycle.
6. Assert rstn=0 after 3 bits, and separately assert it with par_valid=1 pending -> outputs go to 0 asynchronously. Afterwards the next 4 bits produce exactly one clean word.
